control_unit: RTL and testbench

Two-phase fetch/execute sequencer for the 4-bit accumulator CPU. Drives the program-counter, fetch-register, tri-state buffer, accumulator and ALU-function controls of the existing datapath from the latched opcode and the ALU carry/zero outputs. Holds the C/Z flag register and resolves conditional jumps; jump target is assembled outside as {operand, program_byte}.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/instr_decoder.sv | 44 ++++
 rtl/control_unit.sv | 117 +++++++++++
 tb/tb_control_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Opcodes, ALU function codes, sequencer states and the EXECUTE strobe bundle
// shared by the accumulator-CPU control unit and its instruction decoder.
package ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FUNC_W = 3;

  localparam logic [OP_W-1:0] OP_JC     = 4'b0000;
  localparam logic [OP_W-1:0] OP_JNC    = 4'b0001;
  localparam logic [OP_W-1:0] OP_CMPI   = 4'b0010;
  localparam logic [OP_W-1:0] OP_CMPIN  = 4'b0011;
  localparam logic [OP_W-1:0] OP_LIT    = 4'b0100;
  localparam logic [OP_W-1:0] OP_IN     = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOP    = 4'b0110;
  localparam logic [OP_W-1:0] OP_OUT    = 4'b0111;
  localparam logic [OP_W-1:0] OP_JZ     = 4'b1000;
  localparam logic [OP_W-1:0] OP_JNZ    = 4'b1001;
  localparam logic [OP_W-1:0] OP_ADDI   = 4'b1010;
  localparam logic [OP_W-1:0] OP_ADDIN  = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP    = 4'b1100;
  localparam logic [OP_W-1:0] OP_HALT   = 4'b1101;
  localparam logic [OP_W-1:0] OP_NANDI  = 4'b1110;
  localparam logic [OP_W-1:0] OP_NANDIN = 4'b1111;

  localparam logic [FUNC_W-1:0] ALU_PASS_A = 3'b000;
  localparam logic [FUNC_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [FUNC_W-1:0] ALU_PASS_B = 3'b010;
  localparam logic [FUNC_W-1:0] ALU_ADD    = 3'b011;
  localparam logic [FUNC_W-1:0] ALU_NAND   = 3'b100;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  typedef struct packed {
    logic              ct_load;
    logic              ct_en;
    logic              fetch_en;
    logic              tri1_en;
    logic              in_oe;
    logic              tri2_en;
    logic              acc_en;
    logic              out_load;
    logic [FUNC_W-1:0] alu_func;
    logic              flag_upd;
    logic              halt_req;
  } strobe_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the latched opcode and registered flags into the
// EXECUTE-phase strobe bundle, including conditional-jump resolution.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] instr,
  input  logic            c_flag,
  input  logic            z_flag,
  output strobe_t         strb
);

  logic jump;
  logic taken;

  always_comb begin
    strb  = '0;
    jump  = 1'b0;
    taken = 1'b0;
    case (instr)
      OP_JC:     begin jump = 1'b1; taken = c_flag;  end
      OP_JNC:    begin jump = 1'b1; taken = ~c_flag; end
      OP_JZ:     begin jump = 1'b1; taken = z_flag;  end
      OP_JNZ:    begin jump = 1'b1; taken = ~z_flag; end
      OP_JMP:    begin jump = 1'b1; taken = 1'b1;    end
      OP_CMPI:   begin strb.tri1_en = 1'b1; strb.alu_func = ALU_SUB; strb.flag_upd = 1'b1; end
      OP_CMPIN:  begin strb.in_oe   = 1'b1; strb.alu_func = ALU_SUB; strb.flag_upd = 1'b1; end
      OP_LIT:    begin strb.tri1_en = 1'b1; strb.alu_func = ALU_PASS_B; strb.acc_en = 1'b1; end
      OP_IN:     begin strb.in_oe   = 1'b1; strb.alu_func = ALU_PASS_B; strb.acc_en = 1'b1; end
      OP_OUT:    begin strb.alu_func = ALU_PASS_A; strb.tri2_en = 1'b1; strb.out_load = 1'b1; end
      OP_ADDI:   begin strb.tri1_en = 1'b1; strb.alu_func = ALU_ADD; strb.acc_en = 1'b1; strb.flag_upd = 1'b1; end
      OP_ADDIN:  begin strb.in_oe   = 1'b1; strb.alu_func = ALU_ADD; strb.acc_en = 1'b1; strb.flag_upd = 1'b1; end
      OP_NANDI:  begin strb.tri1_en = 1'b1; strb.alu_func = ALU_NAND; strb.acc_en = 1'b1; strb.flag_upd = 1'b1; end
      OP_NANDIN: begin strb.in_oe   = 1'b1; strb.alu_func = ALU_NAND; strb.acc_en = 1'b1; strb.flag_upd = 1'b1; end
      OP_HALT:   strb.halt_req = 1'b1;
      default:   ;
    endcase
    // Untaken jumps still advance the PC past the address byte.
    if (jump) begin
      strb.ct_load = taken;
      strb.ct_en   = ~taken;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/execute sequencer with C/Z flag register for the 4-bit accumulator CPU.
// Define CTRL_STEP_EN to add the step port and a WAIT state between instructions.
module control_unit
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   instr,
  input  logic              carry,
  input  logic              zero,
`ifdef CTRL_STEP_EN
  input  logic              step,
`endif
  output logic              ct_load,
  output logic              ct_en,
  output logic              fetch_en,
  output logic              tri1_en,
  output logic              in_oe,
  output logic              tri2_en,
  output logic              acc_en,
  output logic              out_load,
  output logic [FUNC_W-1:0] alu_func,
  output logic              c_flag,
  output logic              z_flag,
  output logic              phase,
  output logic              halted
);

  state_e  state_q, state_d;
  logic    c_q, z_q;
  strobe_t dec;
  strobe_t strb_c;
  logic    step_rise;

  instr_decoder u_dec (
    .instr  (instr),
    .c_flag (c_q),
    .z_flag (z_q),
    .strb   (dec)
  );

`ifdef CTRL_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step & ~step_q;
`else
  assign step_rise = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    strb_c  = '0;
    case (state_q)
      ST_FETCH: begin
        strb_c.fetch_en = 1'b1;
        strb_c.ct_en    = 1'b1;
        state_d         = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        strb_c = dec;
        if (dec.halt_req) begin
          state_d = ST_HALT;
        end else begin
`ifdef CTRL_STEP_EN
          state_d = ST_WAIT;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_WAIT: begin
        if (step_rise) state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (state_q == ST_EXECUTE && dec.flag_upd) begin
      c_q <= carry;
      z_q <= zero;
    end
  end

  // Strobes are forced low for as long as reset is held, not just after the edge.
  always_comb begin
    ct_load  = reset & strb_c.ct_load;
    ct_en    = reset & strb_c.ct_en;
    fetch_en = reset & strb_c.fetch_en;
    tri1_en  = reset & strb_c.tri1_en;
    in_oe    = reset & strb_c.in_oe;
    tri2_en  = reset & strb_c.tri2_en;
    acc_en   = reset & strb_c.acc_en;
    out_load = reset & strb_c.out_load;
    alu_func = reset ? strb_c.alu_func : ALU_PASS_A;
  end

  assign c_flag = c_q;
  assign z_flag = z_q;
  assign phase  = (state_q == ST_EXECUTE);
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; strobe vectors are packed as
// {ct_load, ct_en, fetch_en, tri1_en, in_oe, tri2_en, acc_en, out_load, alu_func}.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] instr;
  logic       carry;
  logic       zero;
  logic       step;
  logic       ct_load, ct_en, fetch_en, tri1_en, in_oe, tri2_en, acc_en, out_load;
  logic [2:0] alu_func;
  logic       c_flag, z_flag, phase, halted;

  int checks;
  int errors;

  localparam logic [10:0] V_NONE  = 11'b00000000_000;
  localparam logic [10:0] V_FETCH = 11'b01100000_000;

  control_unit dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .carry    (carry),
    .zero     (zero),
`ifdef CTRL_STEP_EN
    .step     (step),
`endif
    .ct_load  (ct_load),
    .ct_en    (ct_en),
    .fetch_en (fetch_en),
    .tri1_en  (tri1_en),
    .in_oe    (in_oe),
    .tri2_en  (tri2_en),
    .acc_en   (acc_en),
    .out_load (out_load),
    .alu_func (alu_func),
    .c_flag   (c_flag),
    .z_flag   (z_flag),
    .phase    (phase),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] strobes();
    return {ct_load, ct_en, fetch_en, tri1_en, in_oe, tri2_en, acc_en, out_load, alu_func};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the post-EXECUTE state and returns to FETCH (pulses step in step builds).
  task automatic to_fetch();
`ifdef CTRL_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; instr = 4'b0110; carry = 1'b1; zero = 1'b1; step = 1'b0;
    tick(); tick();
    checks++;
    if (strobes() !== V_NONE || phase !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold strobes=%b phase=%b halted=%b want %b 0 0", strobes(), phase, halted, V_NONE);
    end
    checks++;
    if ({c_flag, z_flag} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b want 00", {c_flag, z_flag});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (strobes() !== V_FETCH || phase !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch strobes=%b phase=%b want %b 0", strobes(), phase, V_FETCH);
    end
    tick();
    checks++;
    if (strobes() !== V_NONE || phase !== 1'b1) begin
      errors++;
      $display("FAIL nop_exec strobes=%b phase=%b want %b 1", strobes(), phase, V_NONE);
    end
    tick(); to_fetch();
    checks++;
    if (strobes() !== V_FETCH || phase !== 1'b0) begin
      errors++;
      $display("FAIL nop_refetch strobes=%b phase=%b want %b 0", strobes(), phase, V_FETCH);
    end
  endtask

  task automatic test_lit_addi();
    instr = 4'b0100; carry = 1'b1; zero = 1'b1;
    tick();
    checks++;
    if (strobes() !== 11'b00010010_010) begin
      errors++;
      $display("FAIL lit_exec got %b want %b", strobes(), 11'b00010010_010);
    end
    tick(); to_fetch();
    checks++;
    if ({c_flag, z_flag} !== 2'b00) begin
      errors++;
      $display("FAIL lit_flags_hold got %b want 00", {c_flag, z_flag});
    end
    instr = 4'b1010;
    tick();
    carry = 1'b1; zero = 1'b0;
    #1;
    checks++;
    if (strobes() !== 11'b00010010_011) begin
      errors++;
      $display("FAIL addi_exec got %b want %b", strobes(), 11'b00010010_011);
    end
    tick(); to_fetch();
    checks++;
    if ({c_flag, z_flag} !== 2'b10 || phase !== 1'b0) begin
      errors++;
      $display("FAIL addi_flags cz=%b phase=%b want 10 0", {c_flag, z_flag}, phase);
    end
  endtask

  task automatic test_cmpi_jumps();
    instr = 4'b0010;
    tick();
    carry = 1'b0; zero = 1'b1;
    #1;
    checks++;
    if (strobes() !== 11'b00010000_001) begin
      errors++;
      $display("FAIL cmpi_exec got %b want %b", strobes(), 11'b00010000_001);
    end
    tick(); to_fetch();
    checks++;
    if ({c_flag, z_flag} !== 2'b01) begin
      errors++;
      $display("FAIL cmpi_flags got %b want 01", {c_flag, z_flag});
    end
    instr = 4'b1000;
    tick();
    checks++;
    if (strobes() !== 11'b10000000_000) begin
      errors++;
      $display("FAIL jz_taken got %b want %b", strobes(), 11'b10000000_000);
    end
    tick(); to_fetch();
    instr = 4'b1001;
    tick();
    checks++;
    if (strobes() !== 11'b01000000_000) begin
      errors++;
      $display("FAIL jnz_not_taken got %b want %b", strobes(), 11'b01000000_000);
    end
    tick(); to_fetch();
  endtask

  // Mixed instruction stream; inputs during EXECUTE vs expected strobes and flags after.
  task automatic test_back_to_back();
    logic [3:0]  t_op  [13] = '{4'b0011, 4'b0000, 4'b1001, 4'b0001, 4'b0101, 4'b0111, 4'b1111,
                               4'b1000, 4'b0000, 4'b1110, 4'b1011, 4'b1100, 4'b0110};
    logic [1:0]  t_cz  [13] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b10, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11};
    logic [10:0] t_exp [13] = '{11'b00001000_001, 11'b10000000_000, 11'b10000000_000,
                               11'b01000000_000, 11'b00001010_010, 11'b00000101_000,
                               11'b00001010_100, 11'b10000000_000, 11'b01000000_000,
                               11'b00010010_100, 11'b00001010_011, 11'b10000000_000,
                               11'b00000000_000};
    logic [1:0]  t_fl  [13] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                               2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 13; i++) begin
      instr = t_op[i];
      #1;
      checks++;
      if (strobes() !== V_FETCH) begin
        errors++;
        $display("FAIL b2b_fetch[%0d] got %b want %b", i, strobes(), V_FETCH);
      end
      tick();
      {carry, zero} = t_cz[i];
      #1;
      checks++;
      if (strobes() !== t_exp[i] || phase !== 1'b1) begin
        errors++;
        $display("FAIL b2b_exec[%0d] op=%b got %b phase=%b want %b 1", i, t_op[i], strobes(), phase, t_exp[i]);
      end
      tick(); to_fetch();
      checks++;
      if ({c_flag, z_flag} !== t_fl[i]) begin
        errors++;
        $display("FAIL b2b_flags[%0d] got %b want %b", i, {c_flag, z_flag}, t_fl[i]);
      end
    end
  endtask

  task automatic test_halt();
    instr = 4'b1101;
    tick();
    checks++;
    if (strobes() !== V_NONE || halted !== 1'b0 || phase !== 1'b1) begin
      errors++;
      $display("FAIL halt_exec strobes=%b halted=%b phase=%b want %b 0 1", strobes(), halted, phase, V_NONE);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      instr = 4'(i);
      #1;
      checks++;
      if (strobes() !== V_NONE || halted !== 1'b1 || phase !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold[%0d] strobes=%b halted=%b phase=%b want %b 1 0", i, strobes(), halted, phase, V_NONE);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || strobes() !== V_NONE) begin
      errors++;
      $display("FAIL halt_reset halted=%b strobes=%b want 0 %b", halted, strobes(), V_NONE);
    end
    tick();
    instr = 4'b0110;
    reset = 1'b1;
    #1;
    checks++;
    if (strobes() !== V_FETCH || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_restart strobes=%b halted=%b want %b 0", strobes(), halted, V_FETCH);
    end
  endtask

  task automatic test_reset_mid_execute();
    instr = 4'b1010;
    tick();
    carry = 1'b1; zero = 1'b1;
    tick(); to_fetch();
    checks++;
    if ({c_flag, z_flag} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_flags got %b want 11", {c_flag, z_flag});
    end
    tick();
    checks++;
    if (acc_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_acc got %b want 1", acc_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (strobes() !== V_NONE || {c_flag, z_flag} !== 2'b00 || phase !== 1'b0) begin
      errors++;
      $display("FAIL mid_exec_reset strobes=%b cz=%b phase=%b want %b 00 0", strobes(), {c_flag, z_flag}, phase, V_NONE);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (strobes() !== V_FETCH) begin
      errors++;
      $display("FAIL mid_exec_restart got %b want %b", strobes(), V_FETCH);
    end
  endtask

`ifdef CTRL_STEP_EN
  task automatic test_step();
    instr = 4'b0110;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (strobes() !== V_NONE || phase !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL step_wait[%0d] strobes=%b phase=%b want %b 0", i, strobes(), phase, V_NONE);
      end
      tick();
    end
    step = 1'b1;
    tick();
    checks++;
    if (strobes() !== V_FETCH) begin
      errors++;
      $display("FAIL step_fetch got %b want %b", strobes(), V_FETCH);
    end
    tick();
    checks++;
    if (phase !== 1'b1) begin
      errors++;
      $display("FAIL step_exec phase=%b want 1", phase);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (strobes() !== V_NONE || phase !== 1'b0) begin
        errors++;
        $display("FAIL step_held[%0d] strobes=%b phase=%b want %b 0", i, strobes(), phase, V_NONE);
      end
    end
    step = 1'b0;
    tick();
    to_fetch();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lit_addi();
    test_cmpi_jumps();
    test_back_to_back();
    test_halt();
    test_reset_mid_execute();
`ifdef CTRL_STEP_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
